// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings for the multdiv issue/stall controller, reused by the hazard unit and writeback mux.
// Defaults only; the controller takes them as overridable parameters.
package multdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } md_state_t;

   localparam int          MD_TIMEOUT_DEF    = 40;
   localparam logic [4:0]  RSTATUS_REG_DEF   = 5'd30;
   localparam logic [31:0] MULT_EXC_CODE_DEF = 32'd4;
   localparam logic [31:0] DIV_EXC_CODE_DEF  = 32'd5;

endpackage

// File: rtl/multdiv_ctrl_watchdog.sv
// md_watchdog: clearable saturating cycle counter; o_expired flags the last permitted WAIT cycle.
// Registered count, combinational expiry; no backpressure.
module md_watchdog #(
   parameter int TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CW'(TIMEOUT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences the multi-cycle multdiv unit: latch op, pulse start, stall until ready, one writeback beat.
// Accept-to-pulse 1 cycle, RDY-to-writeback 1 cycle; pipeline is held via stall while an op is in flight.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int          TIMEOUT       = MD_TIMEOUT_DEF,
   parameter logic [4:0]  RSTATUS_REG   = RSTATUS_REG_DEF,
   parameter logic [31:0] MULT_EXC_CODE = MULT_EXC_CODE_DEF,
   parameter logic [31:0] DIV_EXC_CODE  = DIV_EXC_CODE_DEF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic        in_is_mult,
   input  logic        in_is_div,
   input  logic [31:0] in_opA,
   input  logic [31:0] in_opB,
   input  logic [4:0]  in_rd,
   input  logic        flush,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        timeout_err
);

   md_state_t   r_state, w_state_nxt;
   logic        r_is_mult;
   logic [31:0] r_opA, r_opB, r_res;
   logic [4:0]  r_rd;
   logic        r_exc;
   logic        r_terr;

   logic        w_accept, w_capture, w_set_terr, w_expired;

   assign w_accept = in_valid & (in_is_mult | in_is_div) & ~flush;

   md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_clr     (r_state == ST_START),
      .i_en      (r_state == ST_WAIT),
      .o_expired (w_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_capture    = 1'b0;
      w_set_terr   = 1'b0;
      stall        = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      unique case (r_state)
         ST_IDLE: begin
            stall = w_accept;
            if (w_accept) w_state_nxt = ST_START;
         end
         ST_START: begin
            stall        = 1'b1;
            md_ctrl_MULT = ~flush & r_is_mult;
            md_ctrl_DIV  = ~flush & ~r_is_mult;
            w_state_nxt  = flush ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            stall = 1'b1;
            // flush beats RDY, RDY beats watchdog expiry
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (md_resultRDY) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_WB;
            end else if (w_expired) begin
               w_set_terr  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WB: begin
            w_state_nxt = ST_IDLE;
            if (r_exc) begin
               wb_rd   = RSTATUS_REG;
               wb_data = r_is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;
            end else begin
               wb_rd   = r_rd;
               wb_data = r_res;
            end
            wb_valid = ~flush & (r_exc | (r_rd != 5'd0));
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_is_mult <= 1'b0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_rd      <= '0;
         r_res     <= '0;
         r_exc     <= 1'b0;
         r_terr    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_accept) begin
            r_is_mult <= in_is_mult;
            r_opA     <= in_opA;
            r_opB     <= in_opB;
            r_rd      <= in_rd;
         end
         if (w_capture) begin
            r_res <= md_result;
            r_exc <= md_exception;
         end
         if (w_set_terr) r_terr <= 1'b1;
      end
   end

   assign md_operandA = r_opA;
   assign md_operandB = r_opB;
   assign busy        = (r_state != ST_IDLE);
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a behavioural multdiv unit and arithmetic reference model.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, in_is_mult, in_is_div, flush;
   logic [31:0] in_opA, in_opB, md_result;
   logic [4:0]  in_rd;
   logic        md_exception, md_resultRDY;
   logic        md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, timeout_err;
   logic [31:0] md_operandA, md_operandB, wb_data;
   logic [4:0]  wb_rd;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   multdiv_ctrl dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_is_mult   (in_is_mult),
      .in_is_div    (in_is_div),
      .in_opA       (in_opA),
      .in_opB       (in_opB),
      .in_rd        (in_rd),
      .flush        (flush),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .md_ctrl_MULT (md_ctrl_MULT),
      .md_ctrl_DIV  (md_ctrl_DIV),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .stall        (stall),
      .busy         (busy),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .timeout_err  (timeout_err)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present an op in the current cycle and advance into START (no checks).
   task automatic issue(input bit mult, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      in_valid = 1'b1; in_is_mult = mult; in_is_div = ~mult;
      in_opA = a; in_opB = b; in_rd = rd;
      step();
      in_valid = 1'b0;
   endtask

   // Full op: accept, pulse, `delay` WAIT cycles (RDY in the last), then WB beat.
   // Returns with time inside the WB cycle, before its closing edge.
   task automatic do_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int delay, input bit rdy_early, input bit flush_wb);
      logic [63:0] p;
      logic [31:0] res, exp_d;
      logic [4:0]  exp_rd;
      bit          exc, exp_v;
      if (mult) begin
         p   = {32'd0, a} * {32'd0, b};
         res = p[31:0];
         exc = (p[63:32] != 32'd0);
      end else begin
         exc = (b == 32'd0);
         res = exc ? 32'hDEAD_BEEF : a / b;
      end
      if (exc) begin
         exp_v = 1'b1; exp_rd = 5'd30; exp_d = mult ? 32'd4 : 32'd5;
      end else begin
         exp_v = (rd != 5'd0); exp_rd = rd; exp_d = res;
      end
      if (flush_wb) exp_v = 1'b0;

      in_valid = 1'b1; in_is_mult = mult; in_is_div = ~mult;
      in_opA = a; in_opB = b; in_rd = rd;
      #1;
      total++;
      if (stall !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL accept: stall=%b busy=%b, want stall=1 busy=0", stall, busy);
      end
      step();
      in_valid = 1'b0; in_opA = $urandom; in_opB = $urandom; in_rd = 5'($urandom);
      md_resultRDY = rdy_early; md_result = $urandom; md_exception = 1'($urandom);
      #1;
      total++;
      if (md_ctrl_MULT !== mult || md_ctrl_DIV !== ~mult || stall !== 1'b1 ||
          md_operandA !== a || md_operandB !== b) begin
         bad++;
         $display("FAIL start_pulse: mult=%b div=%b stall=%b A=%h B=%h, want mult=%b div=%b stall=1 A=%h B=%h",
                  md_ctrl_MULT, md_ctrl_DIV, stall, md_operandA, md_operandB, mult, ~mult, a, b);
      end
      step();
      for (int k = 0; k < delay; k++) begin
         md_resultRDY = (k == delay - 1);
         md_result    = (k == delay - 1) ? res : $urandom;
         md_exception = (k == delay - 1) ? exc : 1'($urandom);
         #1;
         total++;
         if (stall !== 1'b1 || md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0 || wb_valid !== 1'b0 ||
             md_operandA !== a || md_operandB !== b) begin
            bad++;
            $display("FAIL wait_cycle%0d: stall=%b mult=%b div=%b wb_valid=%b A=%h B=%h, want 1/0/0/0 %h %h",
                     k, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, md_operandA, md_operandB, a, b);
         end
         step();
      end
      md_resultRDY = 1'b0; md_exception = 1'b0; md_result = $urandom;
      flush = flush_wb;
      #1;
      total++;
      if (wb_valid !== exp_v || stall !== 1'b0 || busy !== 1'b1 ||
          (exp_v && (wb_rd !== exp_rd || wb_data !== exp_d))) begin
         bad++;
         $display("FAIL writeback: valid=%b rd=%0d data=%h stall=%b busy=%b, want valid=%b rd=%0d data=%h stall=0 busy=1",
                  wb_valid, wb_rd, wb_data, stall, busy, exp_v, exp_rd, exp_d);
      end
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 0; in_is_mult = 0; in_is_div = 0; flush = 0;
      in_opA = 0; in_opB = 0; in_rd = 0; md_result = 0; md_exception = 0; md_resultRDY = 0;
      repeat (2) @(posedge clock);
      #2;
      total++;
      if ({md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, timeout_err} !== 6'd0 ||
          md_operandA !== 32'd0 || md_operandB !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
         bad++; $display("FAIL reset_state: ctl=%b A=%h B=%h rd=%0d data=%h, want all zero",
                         {md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, timeout_err},
                         md_operandA, md_operandB, wb_rd, wb_data);
      end
      @(negedge clock);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_mult();
      do_op(1'b1, 32'd6, 32'd7, 5'd5, 33, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_div();
      do_op(1'b0, 32'd100, 32'd7, 5'd9, 12, 1'b1, 1'b0);
      step();
      do_op(1'b0, 32'd55, 32'd0, 5'd3, 4, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_exceptions();
      do_op(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd7, 8, 1'b0, 1'b0);
      step();
      do_op(1'b1, 32'd3, 32'd3, 5'd0, 2, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_boundary();
      do_op(1'b1, 32'd11, 32'd13, 5'd1, 1, 1'b0, 1'b0);
      step();
      do_op(1'b0, 32'd1000, 32'd10, 5'd31, 40, 1'b0, 1'b0);
      step();
      total++;
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rdy_beats_expiry: timeout_err=%b busy=%b, want 0/0", timeout_err, busy);
      end
   endtask

   task automatic test_flush_start();
      issue(1'b1, 32'd2, 32'd2, 5'd4);
      flush = 1'b1;
      #1;
      total++;
      if (md_ctrl_MULT !== 1'b0 || md_ctrl_DIV !== 1'b0) begin
         bad++; $display("FAIL flush_start_pulse: mult=%b div=%b, want 0/0", md_ctrl_MULT, md_ctrl_DIV);
      end
      step();
      flush = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         bad++; $display("FAIL flush_start_idle: busy=%b stall=%b, want 0/0", busy, stall);
      end
      step();
   endtask

   task automatic test_flush_wait();
      issue(1'b0, 32'd77, 32'd7, 5'd6);
      step();
      for (int k = 1; k < 10; k++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         bad++; $display("FAIL flush_wait_idle: busy=%b stall=%b, want 0/0", busy, stall);
      end
      md_resultRDY = 1'b1; md_result = 32'd11;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_wait_drop%0d: wb_valid=%b busy=%b, want 0/0", k, wb_valid, busy);
         end
      end
      md_resultRDY = 1'b0;
      step();
   endtask

   task automatic test_flush_wb();
      do_op(1'b1, 32'd9, 32'd9, 5'd12, 5, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_back_to_back();
      do_op(1'b1, 32'd4, 32'd5, 5'd2, 3, 1'b0, 1'b0);
      in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b0;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL no_accept_in_wb: stall=%b, want 0", stall);
      end
      step();
      do_op(1'b1, 32'd8, 32'd8, 5'd3, 6, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         bit          m;
         logic [31:0] a, b;
         m = 1'($urandom);
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000));
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 300)));
         do_op(m, a, b, 5'($urandom), $urandom_range(1, 40), 1'($urandom), 1'b0);
         step();
      end
   endtask

   task automatic test_timeout();
      issue(1'b0, 32'd50, 32'd5, 5'd8);
      step();
      for (int k = 0; k < 40; k++) begin
         md_result = $urandom;
         total++;
         if (timeout_err !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL timeout_early%0d: timeout_err=%b stall=%b, want 0/1", k, timeout_err, stall);
         end
         step();
      end
      total++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL timeout_expiry: err=%b busy=%b stall=%b wb_valid=%b, want 1/0/0/0",
                         timeout_err, busy, stall, wb_valid);
      end
      md_resultRDY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if (timeout_err !== 1'b1 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_sticky%0d: err=%b wb_valid=%b, want 1/0", k, timeout_err, wb_valid);
         end
      end
      md_resultRDY = 1'b0;
      step();
      do_op(1'b1, 32'd6, 32'd6, 5'd10, 7, 1'b0, 1'b0);
      step();
      total++;
      if (timeout_err !== 1'b1) begin
         bad++; $display("FAIL timeout_sticky_after_op: err=%b, want 1", timeout_err);
      end
   endtask

   task automatic test_async_reset();
      issue(1'b1, 32'hABCD, 32'h1234, 5'd14);
      for (int k = 0; k < 5; k++) step();
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, timeout_err} !== 6'd0 ||
          md_operandA !== 32'd0 || md_operandB !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
         bad++; $display("FAIL async_reset: ctl=%b A=%h B=%h rd=%0d data=%h, want all zero",
                         {md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, timeout_err},
                         md_operandA, md_operandB, wb_rd, wb_data);
      end
      @(negedge clock);
      reset_n = 1'b1;
      md_resultRDY = 1'b1; md_result = 32'd99;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_drop%0d: wb_valid=%b busy=%b, want 0/0", k, wb_valid, busy);
         end
      end
      md_resultRDY = 1'b0;
      step();
      do_op(1'b0, 32'd81, 32'd9, 5'd17, 9, 1'b0, 1'b0);
      step();
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_exceptions();
      test_boundary();
      test_flush_start();
      test_flush_wait();
      test_flush_wb();
      test_back_to_back();
      test_random();
      test_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Issue/stall controller that sequences the multi-cycle multdiv unit for the 5-stage pipeline. Accepts one mult/div from the execute stage and latches its operands and destination register. Pulses the unit's start control for one cycle, stalls the pipeline until the unit reports ready, then presents one writeback beat, redirecting exceptions to $rstatus. Handles flush, watchdog timeout and asynchronous reset mid-operation.

Parameters:
TIMEOUT, 40, max WAIT cycles before abort (counter width = clog2(TIMEOUT+1))
RSTATUS_REG, 30, writeback register on exception
MULT_EXC_CODE, 4, $rstatus value for mult overflow
DIV_EXC_CODE, 5, $rstatus value for divide-by-zero

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  execute stage holds a mult/div candidate
in_is_mult  in  1  instruction is mult
in_is_div  in  1  instruction is div
in_opA  in  32  operand A
in_opB  in  32  operand B
in_rd  in  5  destination register
flush  in  1  squash the in-flight op (branch/jump resolved)
md_result  in  32  multdiv data_result
md_exception  in  1  multdiv data_exception
md_resultRDY  in  1  multdiv data_resultRDY
md_ctrl_MULT  out  1  one-cycle start pulse to multdiv
md_ctrl_DIV  out  1  one-cycle start pulse to multdiv
md_operandA  out  32  latched operand A
md_operandB  out  32  latched operand B
stall  out  1  freeze PC, F/D and D/X latches
busy  out  1  state != IDLE
wb_valid  out  1  one-cycle writeback beat
wb_rd  out  5  writeback register
wb_data  out  32  writeback data
timeout_err  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, all outputs 0, latched operands/rd/op=0, timeout_err=0. Reset mid-operation aborts immediately; no writeback.
- States: IDLE, START, WAIT, WB.
- IDLE: accept when in_valid & (in_is_mult | in_is_div) & !flush. If both type bits are set, mult wins. On accept, latch opA, opB, rd and op type, then go to START. stall is asserted combinationally in the accept cycle. Otherwise stall=0.
- START (1 cycle): md_ctrl_MULT or md_ctrl_DIV=1 per the latched type, with md_operandA/B driven from the latches. Clear the counter and go to WAIT. stall=1. md_resultRDY is ignored in this cycle.
- WAIT: stall=1 and the counter increments each cycle.
  - If md_resultRDY=1, capture md_result/md_exception and go to WB.
  - Else if counter==TIMEOUT-1, set timeout_err and go to IDLE with no writeback.
  - If RDY and expiry coincide, RDY wins.
- WB (1 cycle): stall=0, so the pipeline advances in this cycle. wb_valid=1 unless it is suppressed (see below). Then go to IDLE. A new accept is possible the following cycle, never in WB itself.
  - No exception: wb_rd=latched rd, wb_data=captured result.
  - Exception: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE per op.
  - wb_valid is suppressed when rd==0 and there is no exception.
- flush:
  - In START: suppress the ctrl pulse and go to IDLE.
  - In WAIT: go to IDLE; the unit's result is dropped.
  - In WB: wb_valid is forced to 0.
  - In IDLE: blocks accept.
  - Flush has priority over RDY and timeout in the same cycle.
- Latency: accept at cycle N, pulse at N+1, WAIT from N+2. If RDY is seen at cycle M, wb_valid is at M+1. stall is high over cycles N..M inclusive.
- md_operandA/B hold the latched values in all states; operands are never re-driven mid-op.
- The counter saturates and is cleared on entry to START.

Decomposition:
- Shared package: state encoding (2-bit), RSTATUS_REG, the exception codes and TIMEOUT default, reused by the hazard unit and the writeback mux.
- One natural sub-module: md_watchdog (a clearable saturating counter with an expiry flag), built from the existing dffe/register primitives.
- FSM, latches and the writeback mux live in multdiv_ctrl.

Test Plan:
- Mult, rd=5, A=6, B=7, model RDY after 33 cycles -> one-cycle md_ctrl_MULT at N+1; stall high N..M; wb_valid=1, wb_rd=5, wb_data=42 at M+1.
- Div, rd=9, A=100, B=7 -> md_ctrl_DIV pulse; wb_rd=9, wb_data=14. Div by zero (B=0, exception) -> wb_rd=30, wb_data=5.
- Mult overflow (0x00010000 * 0x00010000, exception) -> wb_rd=30, wb_data=4. Mult 3*3 with rd=0 -> wb_valid stays 0.
- flush in WAIT cycle 10 -> IDLE, stall low the next cycle, no wb_valid even if RDY arrives later. flush in the START cycle -> no ctrl pulse observed.
- RDY held low -> timeout_err=1 after 40 WAIT cycles, returns to IDLE, no wb_valid; timeout_err stays 1 until reset_n.
- reset_n pulsed low mid-WAIT (between edges) -> all outputs 0 immediately. A back-to-back mult issued in the cycle after WB is accepted.
